// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the program loader and the fetch path.
package cpu_pkg;

   localparam int INSTR_WIDTH = 16;
   localparam int BYTE_WIDTH  = 8;

   // Instruction memory lane order: low byte at the even address, high byte at +1.
   localparam logic LO_BYTE_LANE = 1'b0;
   localparam logic HI_BYTE_LANE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      WR_LO,
      WR_HI,
      DONE
   } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams 16-bit instructions into byte-wide instruction memory as low/high byte pairs,
// holding the CPU in reset (busy) for the whole load session.
module program_loader
   import cpu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     finish,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INSTR_WIDTH-1:0]   in_instr,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [BYTE_WIDTH-1:0]    mem_wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [ADDRESS_WIDTH-1:0] words_loaded
);

   localparam logic [ADDRESS_WIDTH:0] FULL_PTR = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   loader_state_t            state_q, state_d;
   logic [ADDRESS_WIDTH:0]   ptr;
   logic [INSTR_WIDTH-1:0]   hold;
   logic                     finish_q;
   logic                     full;
   logic                     handshake;

   // ptr has one extra bit so "full" is distinguishable from address 0.
   assign full      = (ptr == FULL_PTR);
   assign handshake = (state_q == WAIT) && in_valid && !full;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         words_loaded <= '0;
         overflow     <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  ptr          <= '0;
                  words_loaded <= '0;
                  overflow     <= 1'b0;
                  finish_q     <= 1'b0;
               end
            end
            WAIT: begin
               if (full && in_valid) overflow <= 1'b1;
               if (handshake && finish) finish_q <= 1'b1;
            end
            WR_LO: begin
               if (finish) finish_q <= 1'b1;
            end
            WR_HI: begin
               ptr          <= ptr + (ADDRESS_WIDTH+1)'(2);
               words_loaded <= words_loaded + ADDRESS_WIDTH'(1);
               finish_q     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Data-only holding register; no reset needed.
   always_ff @(posedge clk) begin
      if (handshake) hold <= in_instr;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = WAIT;
         end
         WAIT: begin
            busy     = 1'b1;
            in_ready = !full;
            if (in_valid && !full) state_d = WR_LO;
            else if (finish)       state_d = DONE;
         end
         WR_LO: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {ptr[ADDRESS_WIDTH-1:1], LO_BYTE_LANE};
            mem_wdata = hold[BYTE_WIDTH-1:0];
            state_d   = WR_HI;
         end
         WR_HI: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {ptr[ADDRESS_WIDTH-1:1], HI_BYTE_LANE};
            mem_wdata = hold[INSTR_WIDTH-1:BYTE_WIDTH];
            state_d   = (finish_q || finish) ? DONE : WAIT;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: drives load sessions and compares memory
// writes and status outputs against a word-level model of the instruction store.
module tb_program_loader;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int WORDS = DEPTH / 2;

   logic          clk;
   logic          rst;
   logic          start;
   logic          finish;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_instr;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [AW-1:0] words_loaded;

   int checks   = 0;
   int failures = 0;

   program_loader #(.ADDRESS_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .finish       (finish),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .words_loaded (words_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   // Captured instruction memory as written by the DUT.
   logic        clr_req;
   logic [7:0]  tb_mem [DEPTH];
   int          wr_cnt [DEPTH];

   always @(posedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i] <= 8'hxx;
            wr_cnt[i] <= 0;
         end
      end else if (mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
      end
   end

   // Word-level reference model of one load session.
   logic [7:0] exp_mem [DEPTH];
   int         exp_words;

   function automatic void model_start();
      exp_words = 0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'hxx;
   endfunction

   function automatic void model_accept(input logic [15:0] w);
      if (exp_words < WORDS) begin
         exp_mem[2*exp_words]     = w[7:0];
         exp_mem[2*exp_words + 1] = w[15:8];
         exp_words++;
      end
   endfunction

   task automatic clear_capture();
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
   endtask

   // Leaves the bench at the negedge of the first WAIT cycle.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for in_ready, hands one word over, returns at the WR_HI negedge.
   task automatic send_word(input logic [15:0] w);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_word_ready: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      end else begin
         in_valid = 1'b1;
         in_instr = w;
         model_accept(w);
         @(negedge clk);
         in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic close_session();
      int n = 0;
      @(negedge clk);
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      while (!done && n < 5) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL close_done: done=%0b after %0d cycles, want 1", done, n);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, mem_we, busy, done, overflow} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: rdy/we/busy/done/ovf=%b, want 00000",
                  {in_ready, mem_we, busy, done, overflow});
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
         failures++;
         $display("FAIL reset_values: addr=%0d wdata=%h words=%0d, want 0 0 0",
                  mem_addr, mem_wdata, words_loaded);
      end
   endtask

   task automatic test_single();
      clear_capture();
      model_start();
      pulse_start();
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || words_loaded !== '0) begin
         failures++;
         $display("FAIL single_wait: busy=%b rdy=%b words=%0d, want 1 1 0",
                  busy, in_ready, words_loaded);
      end
      in_valid = 1'b1;
      in_instr = 16'h1405;
      model_accept(16'h1405);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 3'd0 || mem_wdata !== 8'h05 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_wr_lo: we=%b addr=%0d data=%h rdy=%b, want 1 0 05 0",
                  mem_we, mem_addr, mem_wdata, in_ready);
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 3'd1 || mem_wdata !== 8'h14) begin
         failures++;
         $display("FAIL single_wr_hi: we=%b addr=%0d data=%h, want 1 1 14",
                  mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || words_loaded !== 3'(exp_words)) begin
         failures++;
         $display("FAIL single_back_wait: rdy=%b we=%b words=%0d, want 1 0 %0d",
                  in_ready, mem_we, words_loaded, exp_words);
      end
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_done: done=%b busy=%b, want 1 1", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_idle: done=%b busy=%b, want 0 0", done, busy);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (tb_mem[i] !== exp_mem[i]) begin
            failures++;
            $display("FAIL single_mem[%0d]: got %h, want %h", i, tb_mem[i], exp_mem[i]);
         end
      end
   endtask

   task automatic test_fill_overflow();
      logic [15:0] prog [4];
      prog[0] = 16'h1405; prog[1] = 16'hC305; prog[2] = 16'hA5C3; prog[3] = 16'h0001;
      clear_capture();
      model_start();
      pulse_start();
      for (int k = 0; k < 4; k++) send_word(prog[k]);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || overflow !== 1'b0 || words_loaded !== 3'(exp_words)) begin
         failures++;
         $display("FAIL fill_full: rdy=%b ovf=%b words=%0d, want 0 0 %0d",
                  in_ready, overflow, words_loaded, exp_words);
      end
      in_valid = 1'b1;
      in_instr = 16'($urandom);
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || overflow !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_overflow: we=%b ovf=%b rdy=%b, want 0 1 0", mem_we, overflow, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL fill_sticky: we=%b ovf=%b, want 0 1", mem_we, overflow);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (tb_mem[i] !== exp_mem[i] || wr_cnt[i] != 1) begin
            failures++;
            $display("FAIL fill_mem[%0d]: got %h (%0d writes), want %h (1 write)",
                     i, tb_mem[i], wr_cnt[i], exp_mem[i]);
         end
      end
      close_session();
      checks++;
      if (busy !== 1'b0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL fill_idle_ovf: busy=%b ovf=%b, want 0 1", busy, overflow);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (overflow !== 1'b0 || words_loaded !== '0) begin
         failures++;
         $display("FAIL fill_rst_clear: ovf=%b words=%0d, want 0 0", overflow, words_loaded);
      end
   endtask

   task automatic test_finish_with_handshake();
      logic [15:0] w = 16'hBEEF;
      clear_capture();
      model_start();
      pulse_start();
      in_valid = 1'b1;
      in_instr = w;
      finish   = 1'b1;
      model_accept(w);
      @(negedge clk);
      in_valid = 1'b0;
      finish   = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 3'd0 || mem_wdata !== w[7:0] || done !== 1'b0) begin
         failures++;
         $display("FAIL fin_hs_lo: we=%b addr=%0d data=%h done=%b, want 1 0 %h 0",
                  mem_we, mem_addr, mem_wdata, done, w[7:0]);
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 3'd1 || mem_wdata !== w[15:8] || done !== 1'b0) begin
         failures++;
         $display("FAIL fin_hs_hi: we=%b addr=%0d data=%h done=%b, want 1 1 %h 0",
                  mem_we, mem_addr, mem_wdata, done, w[15:8]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || mem_we !== 1'b0 || words_loaded !== 3'd1) begin
         failures++;
         $display("FAIL fin_hs_done: done=%b we=%b words=%0d, want 1 0 1", done, mem_we, words_loaded);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL fin_hs_idle: done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [3];
      int hs_cyc [3];
      int idx = 0;
      int cyc = 0;
      for (int k = 0; k < 3; k++) w[k] = 16'($urandom);
      clear_capture();
      model_start();
      pulse_start();
      in_valid = 1'b1;
      in_instr = w[0];
      while (idx < 3 && cyc < 40) begin
         if (in_ready && in_valid) begin
            hs_cyc[idx] = cyc;
            model_accept(w[idx]);
            idx++;
         end
         @(negedge clk);
         cyc++;
         if (idx >= 3) in_valid = 1'b0;
         else          in_instr = w[idx];
      end
      in_valid = 1'b0;
      checks++;
      if (idx != 3) begin
         failures++;
         $display("FAIL b2b_handshakes: got %0d in %0d cycles, want 3", idx, cyc);
      end else begin
         checks++;
         if (hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
            failures++;
            $display("FAIL b2b_spacing: gaps %0d %0d, want 3 3",
                     hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (words_loaded !== 3'(exp_words) || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_words: words=%0d rdy=%b, want %0d 1", words_loaded, in_ready, exp_words);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (tb_mem[i] !== exp_mem[i] || wr_cnt[i] != ((i < 2*exp_words) ? 1 : 0)) begin
            failures++;
            $display("FAIL b2b_mem[%0d]: got %h (%0d writes), want %h",
                     i, tb_mem[i], wr_cnt[i], exp_mem[i]);
         end
      end
      close_session();
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] w1 = 16'($urandom);
      logic [15:0] w2 = 16'($urandom);
      clear_capture();
      model_start();
      pulse_start();
      in_valid = 1'b1;
      in_instr = w1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 3'd1) begin
         failures++;
         $display("FAIL rstmid_wr_hi: we=%b addr=%0d, want 1 1", mem_we, mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, mem_we, busy, done, overflow} !== 5'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || words_loaded !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs: rdy/we/busy/done/ovf=%b addr=%0d data=%h words=%0d, want 00000 0 00 0",
                  {in_ready, mem_we, busy, done, overflow}, mem_addr, mem_wdata, words_loaded);
      end
      clear_capture();
      model_start();
      pulse_start();
      send_word(w2);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (tb_mem[i] !== exp_mem[i]) begin
            failures++;
            $display("FAIL rstmid_restart_mem[%0d]: got %h, want %h", i, tb_mem[i], exp_mem[i]);
         end
      end
      checks++;
      if (words_loaded !== 3'd1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_restart: words=%0d ovf=%b, want 1 0", words_loaded, overflow);
      end
      close_session();
   endtask

   task automatic test_start_ignored();
      logic [15:0] w [3];
      for (int k = 0; k < 3; k++) w[k] = 16'($urandom);
      clear_capture();
      model_start();
      pulse_start();
      send_word(w[0]);
      send_word(w[1]);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (words_loaded !== 3'd2 || busy !== 1'b1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL start_ignored: words=%0d busy=%b rdy=%b, want 2 1 1",
                  words_loaded, busy, in_ready);
      end
      send_word(w[2]);
      @(negedge clk);
      checks++;
      if (words_loaded !== 3'(exp_words)) begin
         failures++;
         $display("FAIL start_ignored_words: got %0d, want %0d", words_loaded, exp_words);
      end
      for (int i = 0; i < 2*exp_words; i++) begin
         checks++;
         if (tb_mem[i] !== exp_mem[i] || wr_cnt[i] != 1) begin
            failures++;
            $display("FAIL start_ignored_mem[%0d]: got %h (%0d writes), want %h",
                     i, tb_mem[i], wr_cnt[i], exp_mem[i]);
         end
      end
      close_session();
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      finish   = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      clr_req  = 1'b0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_finish_with_handshake();
      test_back_to_back();
      test_reset_mid_write();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the byte-addressable instruction ROM/RAM: accepts 16-bit instructions over a valid/ready stream and stores each as two bytes, low byte at an even address and high byte at that address + 1. The fetch path reads the same pair back as {mem[a+1], mem[a]}. While a load session runs, `busy` holds the program counter and CPU in reset so fetch never sees a half-written program.

## Interface
- ADDRESS_WIDTH, 3, byte-address width of the instruction memory; capacity is 2^(ADDRESS_WIDTH-1) instructions; must be >= 2
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to open a load session; honored only in IDLE
- finish  in  1  one-cycle request to close the session
- in_valid  in  1  in_instr is valid
- in_ready  out  1  loader can accept an instruction this cycle
- in_instr  in  16  instruction word, [7:0] low byte, [15:8] high byte
- mem_we  out  1  byte write enable to instruction memory
- mem_addr  out  ADDRESS_WIDTH  byte write address
- mem_wdata  out  8  byte write data
- busy  out  1  session active; drives CPU/PC reset
- done  out  1  one-cycle pulse at session close
- overflow  out  1  sticky: in_valid seen while memory full; cleared by start or rst
- words_loaded  out  ADDRESS_WIDTH  instructions written this session

## Operation
- States: IDLE, WAIT, WR_LO, WR_HI, DONE.
- IDLE: in_ready=0, busy=0. On start: ptr <- 0, words_loaded <- 0, overflow <- 0, finish latch cleared, go to WAIT.
- WAIT: busy=1. in_ready=1 unless full. Handshake (in_valid & in_ready) latches in_instr into holding register and goes to WR_LO.
- WR_LO: mem_we=1, mem_addr=ptr, mem_wdata=hold[7:0]; next WR_HI.
- WR_HI: mem_we=1, mem_addr=ptr+1, mem_wdata=hold[15:8]; ptr <- ptr+2, words_loaded <- words_loaded+1. Next: DONE if finish is latched, else WAIT.
- DONE: done=1 for exactly one cycle, busy=1; next IDLE.
- ptr is ADDRESS_WIDTH+1 bits and always even; mem_addr = low ADDRESS_WIDTH bits. Full when ptr == 2^ADDRESS_WIDTH. No wrap-around: a full memory never overwrites address 0.
- Full in WAIT: in_ready=0. Any cycle with in_valid=1 sets overflow. No write happens.
- finish in WAIT goes to DONE next cycle. finish together with a handshake in WAIT: the instruction is accepted and written, then DONE. finish in WR_LO or WR_HI is latched and honored after WR_HI.
- start outside IDLE is ignored. finish in IDLE or DONE is ignored.
- mem_we=0 in every state except WR_LO and WR_HI.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, overflow 0, words_loaded 0, ptr 0.
- start at edge N puts the block in WAIT at N+1, with in_ready=1 and busy=1 in that cycle.
- Handshake at cycle N: WR_LO at N+1, WR_HI at N+2, WAIT with in_ready=1 at N+3. Throughput is 1 instruction per 3 cycles.
- finish in WAIT at cycle N: done=1 at N+1, IDLE with busy=0 at N+2.
- rst during WR_LO or WR_HI aborts at the next edge. A partially written byte pair stays in memory; software must reload.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready.

## Structure
- Shared `cpu_pkg`: INSTR_WIDTH=16, BYTE_WIDTH=8, loader_state_t enum (IDLE, WAIT, WR_LO, WR_HI, DONE). The instruction-memory byte-lane ordering (low byte at even address) is defined in the same package as a constant comment and is shared with fetch.
- Single module with no sub-module. The FSM, pointer and holding register are small enough to stay flat.

## Test plan
- Load 0x1405 after start: writes mem[0]=0x05 at N+1 and mem[1]=0x14 at N+2; words_loaded=1. Then finish gives done pulse and busy=0.
- Load 4 instructions 0x1405, 0xC305, 0xA5C3, 0x0001 (ADDRESS_WIDTH=3): bytes land at 0..7 in low/high order. in_ready=0 afterwards; a further in_valid sets overflow=1 and mem_we stays 0.
- finish asserted in the same cycle as a handshake of 0xBEEF: both bytes are written, then done pulses one cycle after WR_HI.
- Hold in_valid=1 continuously with 3 words: exactly 3 handshakes occur, spaced 3 cycles apart, with no duplicate writes.
- Assert rst in WR_HI: next cycle all outputs are at reset values and the state is IDLE. A new start restarts at ptr=0 with overflow cleared.
- start pulsed while in WAIT with words_loaded=2: ignored; ptr and words_loaded unchanged.
